// File: rtl/peak_frame_packer.sv
// Buffers one frame of per-range-bin peak results, tags each against a threshold,
// and streams the frame out as a header plus two words per bin over valid/ready.
module peak_frame_packer #(
  parameter int TOTAL_RANGEBIN = 9,
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pk_en,
  input  logic              pk_valid,
  input  logic [DATA_W-1:0] pk_value,
  input  logic [ADDR_W-1:0] pk_addr,
  input  logic [DATA_W-1:0] thresh,
  output logic [31:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [15:0]       frame_cnt,
  output logic              ovf_err
);

  localparam int BIN_W  = (TOTAL_RANGEBIN > 1) ? $clog2(TOTAL_RANGEBIN) : 1;
  localparam int WORD_W = $clog2(2 * TOTAL_RANGEBIN + 1);
  localparam logic [BIN_W-1:0]  LAST_BIN  = BIN_W'(TOTAL_RANGEBIN - 1);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(2 * TOTAL_RANGEBIN);

  typedef enum logic [1:0] {IDLE, COLLECT, SEND} state_t;

  state_t              state;
  logic [BIN_W-1:0]    bin_idx;
  logic [WORD_W-1:0]   word_idx;
  logic [DATA_W-1:0]   thr_reg;

  logic [DATA_W-1:0]   slot_value [TOTAL_RANGEBIN];
  logic [ADDR_W-1:0]   slot_addr  [TOTAL_RANGEBIN];
  logic                slot_hit   [TOTAL_RANGEBIN];

  logic                slot_wr;
  logic [WORD_W-1:0]   next_idx;
  logic [BIN_W-1:0]    next_bin;
  logic [31:0]         next_word;
  logic [31:0]         header;

  assign slot_wr = (state == COLLECT) && pk_en && pk_valid;
  assign header  = {8'hA5, 4'h0, 4'(TOTAL_RANGEBIN), frame_cnt};

  // Words 2k+1 and 2k+2 both belong to bin k, which is word_idx>>1 for the word after word_idx.
  always_comb begin
    next_idx  = word_idx + WORD_W'(1);
    next_bin  = BIN_W'(word_idx >> 1);
    next_word = '0;
    if (next_idx[0]) next_word = 32'(slot_value[next_bin]);
    else             next_word = {slot_hit[next_bin], 31'(slot_addr[next_bin])};
  end

  always_ff @(posedge clk) begin
    if (slot_wr) begin
      slot_value[bin_idx] <= pk_value;
      slot_addr[bin_idx]  <= pk_addr;
      slot_hit[bin_idx]   <= (pk_value >= thr_reg);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bin_idx   <= '0;
      word_idx  <= '0;
      thr_reg   <= '0;
      frame_cnt <= '0;
      ovf_err   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      if (pk_en && pk_valid && (state != COLLECT)) ovf_err <= 1'b1;

      case (state)
        IDLE: begin
          if (pk_en) begin
            state   <= COLLECT;
            thr_reg <= thresh;
            bin_idx <= '0;
          end
        end

        COLLECT: begin
          if (!pk_en) begin
            state   <= IDLE;
            bin_idx <= '0;
          end else if (pk_valid) begin
            if (bin_idx == LAST_BIN) begin
              state     <= SEND;
              bin_idx   <= '0;
              word_idx  <= '0;
              out_valid <= 1'b1;
              out_last  <= 1'b0;
              out_data  <= header;
            end else begin
              bin_idx <= bin_idx + BIN_W'(1);
            end
          end
        end

        SEND: begin
          // A completed final-word transfer counts the frame even if pk_en drops in the same cycle.
          if (out_ready && out_last) begin
            frame_cnt <= frame_cnt + 16'd1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            bin_idx   <= '0;
            if (pk_en) begin
              state   <= COLLECT;
              thr_reg <= thresh;
            end else begin
              state <= IDLE;
            end
          end else if (!pk_en) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            bin_idx   <= '0;
          end else if (out_ready) begin
            word_idx <= next_idx;
            out_data <= next_word;
            out_last <= (next_idx == LAST_WORD);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_peak_frame_packer.sv
// Self-checking bench for peak_frame_packer: frames are predicted from the peak list,
// threshold and frame count, then compared word by word with what the stream delivers.
module tb_peak_frame_packer;

  localparam int NB = 9;
  localparam int NW = 1 + 2 * NB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pk_en = 1'b0;
  logic        pk_valid = 1'b0;
  logic [31:0] pk_value = '0;
  logic [9:0]  pk_addr = '0;
  logic [31:0] thresh = '0;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic [15:0] frame_cnt;
  logic        ovf_err;

  peak_frame_packer #(.TOTAL_RANGEBIN(NB), .DATA_W(32), .ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .pk_en(pk_en), .pk_valid(pk_valid),
    .pk_value(pk_value), .pk_addr(pk_addr), .thresh(thresh),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .frame_cnt(frame_cnt), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] pv [NB];
  logic [9:0]  pa [NB];
  logic [32:0] got [$];
  int          ready_mode = 0;
  int          stall_at = -1;
  int          stall_left = 0;
  logic        ready_tog = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;

  // Expected stream word w (with its last flag in bit 32) for the current peak list.
  function automatic logic [32:0] exp_word(int w, logic [31:0] thr, logic [15:0] fc);
    logic [31:0] d;
    int k;
    if (w == 0) begin
      d = {8'hA5, 4'h0, 4'(NB), fc};
    end else begin
      k = (w - 1) / 2;
      if (w % 2 == 1) d = pv[k];
      else            d = {(pv[k] >= thr), 21'b0, pa[k]};
    end
    return {(w == NW - 1), d};
  endfunction

  // One clock: sample at the falling edge, pick out_ready for the next rising edge, log transfers.
  task automatic cycle();
    logic r;
    @(negedge clk);
    if (prev_stall) begin
      n_cmp++;
      if ({out_valid, out_last, out_data} !== {1'b1, prev_last, prev_data})
        $display("FAIL hold_stable: got v=%b l=%b d=%h, need v=1 l=%b d=%h",
                 out_valid, out_last, out_data, prev_last, prev_data);
      if ({out_valid, out_last, out_data} !== {1'b1, prev_last, prev_data}) n_bad++;
    end
    if (stall_left > 0) begin
      r = 1'b0;
      stall_left--;
    end else if (stall_at >= 0 && out_valid && got.size() == stall_at) begin
      r = 1'b0;
      stall_left = 9;
      stall_at = -1;
    end else begin
      case (ready_mode)
        0: r = 1'b1;
        1: begin ready_tog = ~ready_tog; r = ready_tog; end
        default: r = 1'($urandom_range(0, 1));
      endcase
    end
    out_ready = r;
    if (out_valid && r) got.push_back({out_last, out_data});
    prev_stall = out_valid && !r;
    prev_data  = out_data;
    prev_last  = out_last;
  endtask

  task automatic gen_spec_peaks();
    for (int k = 0; k < NB; k++) begin
      pv[k] = 32'(50 * k);
      pa[k] = 10'(512 + k);
    end
  endtask

  task automatic gen_rand_peaks(input logic [31:0] thr);
    for (int k = 0; k < NB; k++) begin
      pv[k] = ($urandom_range(0, 3) == 0) ? thr : $urandom_range(0, 2 * thr);
      pa[k] = 10'($urandom);
    end
  endtask

  task automatic feed(input int first, input int count, input int gap_max);
    for (int k = first; k < first + count; k++) begin
      repeat ($urandom_range(0, gap_max)) cycle();
      pk_valid = 1'b1;
      pk_value = pv[k];
      pk_addr  = pa[k];
      cycle();
      pk_valid = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 400;
    while (got.size() < NW && budget > 0) begin
      cycle();
      budget--;
    end
    n_cmp++;
    if (budget == 0) begin
      n_bad++;
      $display("FAIL %s_timeout: got %0d words, need %0d", name, got.size(), NW);
    end
  endtask

  task automatic check_frame(input string name, input logic [31:0] thr, input logic [15:0] fc);
    n_cmp++;
    if (got.size() != NW) begin
      n_bad++;
      $display("FAIL %s_count: got %0d words, need %0d", name, got.size(), NW);
    end
    for (int i = 0; i < NW && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp_word(i, thr, fc)) begin
        n_bad++;
        $display("FAIL %s_word%0d: got last=%b data=%h, need last=%b data=%h", name, i,
                 got[i][32], got[i][31:0], exp_word(i, thr, fc) >> 32, exp_word(i, thr, fc) & 33'hFFFF_FFFF);
      end
    end
  endtask

  task automatic check_cnt(input string name, input logic [15:0] exp_fc, input logic exp_ovf);
    n_cmp++;
    if (frame_cnt !== exp_fc || ovf_err !== exp_ovf) begin
      n_bad++;
      $display("FAIL %s_status: got frame_cnt=%h ovf=%b, need frame_cnt=%h ovf=%b",
               name, frame_cnt, ovf_err, exp_fc, exp_ovf);
    end
  endtask

  task automatic finish_idle();
    pk_en = 1'b0;
    repeat (3) cycle();
    got.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();
    n_cmp++;
    if ({out_valid, out_last, out_data} !== 34'b0) begin
      n_bad++;
      $display("FAIL reset_out: got v=%b l=%b d=%h, need all zero", out_valid, out_last, out_data);
    end
    check_cnt("reset", 16'h0000, 1'b0);
  endtask

  task automatic test_basic();
    gen_spec_peaks();
    thresh = 32'd100;
    ready_mode = 0;
    got.delete();
    pk_en = 1'b1;
    cycle();
    feed(0, NB, 0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 32'hA509_0000) begin
      n_bad++;
      $display("FAIL basic_latency: got v=%b d=%h, need v=1 d=a5090000", out_valid, out_data);
    end
    drain("basic");
    cycle();
    check_frame("basic", 32'd100, 16'd0);
    check_cnt("basic", 16'd1, 1'b0);
    finish_idle();
  endtask

  task automatic test_backpressure();
    gen_spec_peaks();
    thresh = 32'd100;
    ready_mode = 1;
    stall_at = 7;
    pk_en = 1'b1;
    cycle();
    feed(0, NB, 0);
    drain("bp");
    cycle();
    check_frame("bp", 32'd100, 16'd1);
    check_cnt("bp", 16'd2, 1'b0);
    ready_mode = 0;
    finish_idle();
  endtask

  task automatic test_overflow();
    logic [31:0] thr;
    thr = $urandom_range(1000, 32'h0FFF_FFFF);
    gen_rand_peaks(thr);
    thresh = thr;
    ready_mode = 2;
    pk_en = 1'b1;
    cycle();
    feed(0, NB, 2);
    pk_valid = 1'b1;
    pk_value = 32'h0000_DEAD;
    pk_addr  = 10'h3FF;
    cycle();
    pk_valid = 1'b0;
    check_cnt("ovf_flag", 16'd2, 1'b1);
    drain("ovf");
    cycle();
    check_frame("ovf", thr, 16'd2);
    finish_idle();
    thr = $urandom_range(1000, 32'h0FFF_FFFF);
    gen_rand_peaks(thr);
    thresh = thr;
    pk_en = 1'b1;
    cycle();
    feed(0, NB, 1);
    drain("ovf_next");
    cycle();
    check_frame("ovf_next", thr, 16'd3);
    check_cnt("ovf_sticky", 16'd4, 1'b1);
    ready_mode = 0;
    finish_idle();
  endtask

  task automatic test_reset_mid_send();
    int budget;
    logic [31:0] thr;
    thr = $urandom_range(1000, 32'h0FFF_FFFF);
    gen_rand_peaks(thr);
    thresh = thr;
    ready_mode = 0;
    pk_en = 1'b1;
    cycle();
    feed(0, NB, 0);
    budget = 100;
    while (got.size() < 10 && budget > 0) begin
      cycle();
      budget--;
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_last, out_data} !== 34'b0) begin
      n_bad++;
      $display("FAIL rst_mid_out: got v=%b l=%b d=%h, need all zero", out_valid, out_last, out_data);
    end
    check_cnt("rst_mid", 16'd0, 1'b0);
    pk_en = 1'b0;
    prev_stall = 1'b0;
    cycle();
    rst_n = 1'b1;
    repeat (3) cycle();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_idle: got out_valid=%b, need 0", out_valid);
    end
    got.delete();
  endtask

  task automatic test_abort();
    logic [31:0] thr;
    thr = $urandom_range(1000, 32'h0FFF_FFFF);
    gen_rand_peaks(thr);
    thresh = thr;
    ready_mode = 2;
    got.delete();
    pk_en = 1'b1;
    cycle();
    feed(0, 5, 1);
    pk_en = 1'b0;
    cycle();
    pk_valid = 1'b1;
    pk_value = 32'h1234_5678;
    cycle();
    pk_valid = 1'b0;
    repeat (3) cycle();
    n_cmp++;
    if (out_valid !== 1'b0 || got.size() != 0 || ovf_err !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_quiet: got v=%b words=%0d ovf=%b, need v=0 words=0 ovf=0",
               out_valid, got.size(), ovf_err);
    end
    thr = $urandom_range(1000, 32'h0FFF_FFFF);
    gen_rand_peaks(thr);
    thresh = thr;
    pk_en = 1'b1;
    cycle();
    feed(0, NB, 1);
    drain("abort");
    cycle();
    check_frame("abort", thr, 16'd0);
    check_cnt("abort", 16'd1, 1'b0);
    ready_mode = 0;
    finish_idle();
  endtask

  task automatic test_wrap();
    logic [31:0] thr;
    force dut.frame_cnt = 16'hFFFF;
    cycle();
    release dut.frame_cnt;
    cycle();
    check_cnt("wrap_preload", 16'hFFFF, 1'b0);
    thr = $urandom_range(1000, 32'h0FFF_FFFF);
    gen_rand_peaks(thr);
    thresh = thr;
    ready_mode = 0;
    got.delete();
    pk_en = 1'b1;
    cycle();
    feed(0, NB, 0);
    drain("wrapA");
    check_frame("wrapA", thr, 16'hFFFF);
    thr = $urandom_range(1000, 32'h0FFF_FFFF);
    thresh = thr;
    gen_rand_peaks(thr);
    got.delete();
    cycle();
    check_cnt("wrap_zero", 16'h0000, 1'b0);
    feed(0, NB, 0);
    drain("wrapB");
    cycle();
    check_frame("wrapB", thr, 16'h0000);
    check_cnt("wrapB", 16'h0001, 1'b0);
    finish_idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_reset_mid_send();
    test_abort();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1, "watchdog expired");
  end

endmodule
